// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arbiter_pkg;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DEBUG = 1'b1;

    localparam int unsigned DEFAULT_DEPTH    = 256;
    localparam int unsigned DEFAULT_LOCK_MAX = 16;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-input round-robin picker; the pointer records the port granted most recently.
module imem_rr_pick
    import imem_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_f,
    input  logic req_d,
    input  logic upd,
    input  logic upd_id,
    output logic pick_valid,
    output logic pick_id
);

    logic last_id;

    // Pointer follows the actual grant, including lock-mode grants chosen outside this picker.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_id <= PORT_DEBUG;
        end else if (upd) begin
            last_id <= upd_id;
        end
    end

    always_comb begin
        pick_valid = req_f | req_d;
        pick_id    = PORT_FETCH;
        if (req_f && req_d) begin
            pick_id = (last_id == PORT_FETCH) ? PORT_DEBUG : PORT_FETCH;
        end else if (req_d) begin
            pick_id = PORT_DEBUG;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates fetch and debug ports onto one synchronous-read instruction memory,
// with a debug lock mode that still yields one fetch slot every LOCK_MAX debug grants.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned LOCK_MAX = DEFAULT_LOCK_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    input  logic        d_lock,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        locked
);

    localparam int unsigned CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    arb_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic        pick_valid, pick_id;
    logic        gnt_valid, gnt_id, gnt_err;
    logic [31:0] gnt_addr;
    logic        lock_hold, force_fetch;

    logic pend_valid, pend_id, pend_err;
    logic rsp_ok;

    imem_rr_pick u_pick (
        .clock      (clock),
        .reset      (reset),
        .req_f      (f_req),
        .req_d      (d_req),
        .upd        (gnt_valid),
        .upd_id     (gnt_id),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RR;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_id    <= PORT_FETCH;
            pend_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pend_valid <= gnt_valid;
            pend_id    <= gnt_id;
            pend_err   <= gnt_err;
        end
    end

    // A LOCKED cycle with d_lock low is arbitrated exactly like RR.
    always_comb begin
        lock_hold   = (state == ST_LOCKED) && d_lock;
        force_fetch = lock_hold && f_req && (cnt == CNT_MAX);

        gnt_valid = 1'b0;
        gnt_id    = PORT_FETCH;
        if (!reset) begin
            if (force_fetch) begin
                gnt_valid = 1'b1;
                gnt_id    = PORT_FETCH;
            end else if (lock_hold) begin
                gnt_valid = d_req;
                gnt_id    = PORT_DEBUG;
            end else begin
                gnt_valid = pick_valid;
                gnt_id    = pick_id;
            end
        end

        f_gnt    = gnt_valid && (gnt_id == PORT_FETCH);
        d_gnt    = gnt_valid && (gnt_id == PORT_DEBUG);
        gnt_addr = (gnt_id == PORT_FETCH) ? f_addr : d_addr;
        gnt_err  = gnt_addr >= 32'(DEPTH);
        mem_addr = (gnt_valid && !gnt_err) ? gnt_addr : '0;
    end

    // The grant that enters LOCKED counts toward the lock budget.
    always_comb begin
        state_nx = ST_RR;
        if (d_lock && ((state == ST_LOCKED) || d_gnt)) begin
            state_nx = ST_LOCKED;
        end

        cnt_nx = cnt;
        if ((state_nx == ST_RR) || force_fetch) begin
            cnt_nx = '0;
        end else if (d_gnt && (cnt != CNT_MAX)) begin
            cnt_nx = cnt + 1'b1;
        end
    end

    always_comb begin
        rsp_ok   = pend_valid && !reset;
        f_rvalid = rsp_ok && (pend_id == PORT_FETCH);
        d_rvalid = rsp_ok && (pend_id == PORT_DEBUG);
        f_err    = f_rvalid && pend_err;
        d_err    = d_rvalid && pend_err;
        f_rdata  = (f_rvalid && !pend_err) ? mem_rdata : '0;
        d_rdata  = (d_rvalid && !pend_err) ? mem_rdata : '0;
        locked   = (state == ST_LOCKED) && !reset;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural synchronous-read memory.
module tb_imem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        d_lock = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        locked;

    int unsigned checks = 0;
    int unsigned failures = 0;

    imem_arbiter #(.DEPTH(256), .LOCK_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .d_lock    (d_lock),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge clock) mem_rdata <= word(mem_addr);

    task automatic cyc(input logic rst, input logic fr, input logic [31:0] fa,
                       input logic dr, input logic [31:0] da, input logic dl);
        @(negedge clock);
        reset = rst; f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_lock = dl;
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1'b1, 1'b1, 3, 1'b1, 4, 1'b1);
        checks++; if ({f_gnt, d_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got %b want 00", {f_gnt, d_gnt}); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        checks++; if ({locked, f_rvalid, d_rvalid, f_err, d_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b want 00000", {locked, f_rvalid, d_rvalid, f_err, d_err}); end
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if ({f_rvalid, d_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_no_rsp got %b want 00", {f_rvalid, d_rvalid}); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
        checks++; if ({f_gnt, d_gnt} !== 2'b10) begin failures++; $display("FAIL single_gnt got %b want 10", {f_gnt, d_gnt}); end
        checks++; if (mem_addr !== 32'd3) begin failures++; $display("FAIL single_mem_addr got %0d want 3", mem_addr); end
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if ({f_rvalid, f_err, d_rvalid} !== 3'b100) begin failures++; $display("FAIL single_rvalid got %b want 100", {f_rvalid, f_err, d_rvalid}); end
        checks++; if (f_rdata !== word(3)) begin failures++; $display("FAIL single_rdata got %h want %h", f_rdata, word(3)); end
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if ({f_rvalid, f_rdata} !== 33'd0) begin failures++; $display("FAIL single_idle got %b/%h want 0/0", f_rvalid, f_rdata); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) cyc(1'b0, 1'b1, 10, 1'b1, 20, 1'b0);
            else       cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
            if (i < 4) begin
                checks++;
                if ({f_gnt, d_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL rr_gnt cycle %0d got %b want %b", i, {f_gnt, d_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
                checks++;
                if (mem_addr !== ((i % 2 == 0) ? 32'd10 : 32'd20)) begin
                    failures++; $display("FAIL rr_mem_addr cycle %0d got %0d", i, mem_addr);
                end
            end
            if (i > 0) begin
                checks++;
                if ({f_rvalid, d_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL rr_rvalid cycle %0d got %b want %b", i, {f_rvalid, d_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
                end
                checks++;
                if ((i % 2 == 1) ? (f_rdata !== word(10) || d_rdata !== 32'd0)
                                 : (d_rdata !== word(20) || f_rdata !== 32'd0)) begin
                    failures++; $display("FAIL rr_rdata cycle %0d got f=%h d=%h", i, f_rdata, d_rdata);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        cyc(1'b0, 1'b0, 0, 1'b1, 300, 1'b0);
        checks++; if ({f_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL oor_gnt got %b want 01", {f_gnt, d_gnt}); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL oor_mem_addr got %0d want 0", mem_addr); end
        cyc(1'b0, 1'b0, 0, 1'b1, 255, 1'b0);
        checks++; if ({d_rvalid, d_err, f_rvalid} !== 3'b110) begin failures++; $display("FAIL oor_err got %b want 110", {d_rvalid, d_err, f_rvalid}); end
        checks++; if (d_rdata !== 32'd0) begin failures++; $display("FAIL oor_rdata got %h want 0", d_rdata); end
        checks++; if (mem_addr !== 32'd255) begin failures++; $display("FAIL edge_mem_addr got %0d want 255", mem_addr); end
        cyc(1'b0, 1'b0, 0, 1'b1, 256, 1'b0);
        checks++; if ({d_rvalid, d_err} !== 2'b10) begin failures++; $display("FAIL edge_err got %b want 10", {d_rvalid, d_err}); end
        checks++; if (d_rdata !== word(255)) begin failures++; $display("FAIL edge_rdata got %h want %h", d_rdata, word(255)); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL depth_mem_addr got %0d want 0", mem_addr); end
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'd0}) begin failures++; $display("FAIL depth_err got %b/%b/%h want 1/1/0", d_rvalid, d_err, d_rdata); end
    endtask

    task automatic test_lock();
        int unsigned exp_dg[12] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        logic prev_d;
        do_reset();
        prev_d = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 7, 1'b1, 9, 1'b1);
            checks++;
            if ({f_gnt, d_gnt} !== ((exp_dg[i] == 1) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL lock_gnt cycle %0d got %b want %b", i, {f_gnt, d_gnt}, (exp_dg[i] == 1) ? 2'b01 : 2'b10);
            end
            checks++;
            if (locked !== (i >= 2)) begin
                failures++; $display("FAIL lock_state cycle %0d got %b want %b", i, locked, i >= 2);
            end
            if (i > 0) begin
                checks++;
                if ({f_rvalid, d_rvalid} !== (prev_d ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL lock_rvalid cycle %0d got %b", i, {f_rvalid, d_rvalid});
                end
            end
            prev_d = (exp_dg[i] == 1);
        end
        cyc(1'b0, 1'b1, 7, 1'b1, 9, 1'b0);
        checks++; if ({f_gnt, d_gnt} !== 2'b10) begin failures++; $display("FAIL unlock_gnt got %b want 10", {f_gnt, d_gnt}); end
        cyc(1'b0, 1'b1, 7, 1'b1, 9, 1'b0);
        checks++; if ({locked, f_gnt, d_gnt} !== 3'b001) begin failures++; $display("FAIL unlock_rr got %b want 001", {locked, f_gnt, d_gnt}); end
    endtask

    task automatic test_lock_saturate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 0, 1'b1, 9, 1'b1);
            checks++;
            if ({f_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL sat_gnt cycle %0d got %b want 01", i, {f_gnt, d_gnt}); end
        end
        cyc(1'b0, 1'b1, 7, 1'b1, 9, 1'b1);
        checks++; if ({locked, f_gnt, d_gnt} !== 3'b110) begin failures++; $display("FAIL sat_force got %b want 110", {locked, f_gnt, d_gnt}); end
        cyc(1'b0, 1'b1, 7, 1'b1, 9, 1'b1);
        checks++; if ({f_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL sat_resume got %b want 01", {f_gnt, d_gnt}); end
        cyc(1'b0, 1'b1, 7, 1'b0, 9, 1'b1);
        checks++; if ({locked, f_gnt, d_gnt} !== 3'b100) begin failures++; $display("FAIL lock_blocks_fetch got %b want 100", {locked, f_gnt, d_gnt}); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cyc(1'b0, 1'b1, 5, 1'b0, 0, 1'b0);
        checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got %b want 1", f_gnt); end
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if ({f_rvalid, f_rdata} !== 33'd0) begin failures++; $display("FAIL mid_reset_rsp got %b/%h want 0/0", f_rvalid, f_rdata); end
        cyc(1'b0, 1'b1, 5, 1'b1, 6, 1'b0);
        checks++; if ({f_gnt, d_gnt, f_rvalid, d_rvalid} !== 4'b1000) begin failures++; $display("FAIL mid_post_reset got %b want 1000", {f_gnt, d_gnt, f_rvalid, d_rvalid}); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_out_of_range();
        test_lock();
        test_lock_saturate();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256, meaning number of 32-bit words in the shared instruction memory; addresses are word indices.
REQ-002 Parameter LOCK_MAX, default 16, meaning maximum consecutive debug grants while locked before one forced fetch slot.
REQ-003 One clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock shared with the instruction memory.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 f_req  input  1  fetch requester read request; held until granted.
REQ-007 f_addr  input  32  fetch word address.
REQ-008 f_gnt  output  1  fetch request accepted this cycle.
REQ-009 f_rvalid  output  1  fetch read data valid.
REQ-010 f_rdata  output  32  fetch read data.
REQ-011 f_err  output  1  fetch address out of range; qualifies f_rvalid.
REQ-012 d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err  (1, 32, 1, 1, 32, 1)  debug/loader port; same meanings as the fetch port.
REQ-013 d_lock  input  1  debug requests exclusive back-to-back access.
REQ-014 mem_addr  output  32  address to the memory; combinational from the granted port; 0 when idle.
REQ-015 mem_rdata  input  32  memory read data; valid one cycle after the address cycle (synchronous read).
REQ-016 locked  output  1  arbiter is in the LOCKED state.

Function
REQ-017 Grant: at most one of f_gnt or d_gnt is asserted per cycle, only for a port whose req=1; throughput is one grant per cycle.
REQ-018 RR state: a single requester wins; when both request, the port not granted most recently wins; after reset, fetch wins first.
REQ-019 Response latency is exactly 1 cycle: a grant in cycle N produces x_rvalid=1 for that port only in cycle N+1, with x_rdata=mem_rdata.
REQ-020 Out of range: an address >= DEPTH still receives a grant and, in N+1, x_rvalid=1, x_err=1, x_rdata=0; mem_addr is driven 0 in cycle N.
REQ-021 x_rdata is 0 whenever x_rvalid=0.
REQ-022 RR->LOCKED occurs when d_gnt=1 and d_lock=1 in the same cycle.
REQ-023 In LOCKED, only debug is granted, while d_req=1; the lock counter increments per d_gnt.
REQ-024 LOCKED->RR occurs on any cycle where d_lock=0; that cycle is arbitrated under RR rules.
REQ-025 When the lock counter reaches LOCK_MAX and f_req=1, the next cycle grants fetch, the counter clears, and the state stays LOCKED; if f_req=0, the counter saturates and debug continues.
REQ-026 The response path is independent of later grants, so a grant in N+1 coexists with the response to N.

Reset
REQ-027 While reset=1: all outputs are 0, the state is RR, the lock counter is 0, the last-grant pointer is "debug", and no pending response exists.
REQ-028 Reset takes priority over everything: a grant issued in the cycle reset rises produces no response afterward.

Structure
REQ-029 A shared package holds the state enum (RR, LOCKED), the port-ID constants (FETCH=0, DEBUG=1), and the default DEPTH/LOCK_MAX.
REQ-030 One sub-module, imem_rr_pick, is natural: a two-input round-robin picker with a last-grant pointer.
REQ-031 Pending-response tracking is a registered valid, port-ID and err flag; no data buffering.

Verification
REQ-032 Reset, then f_req=1 with f_addr=3, d_req=0 -> f_gnt in cycle 0, mem_addr=3, f_rvalid=1 in cycle 1 with the memory word 3.
REQ-033 f_req=d_req=1 held for 4 cycles -> grants F,D,F,D; each rvalid lands on the matching port one cycle later.
REQ-034 d_addr=300 with DEPTH=256 -> d_gnt, mem_addr=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-035 d_lock=1 with both requesting, LOCK_MAX=4 -> 4 debug grants, 1 fetch grant, repeating; locked=1; dropping d_lock returns to RR in the same cycle.
REQ-036 Assert reset in the cycle after a grant -> no rvalid is seen; the first post-reset contention grants fetch.
